// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM states, requester IDs, widths.
package data_mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DISP = 1'b1
  } req_id_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester and RAM-side signals of the data-memory arbiter; slave = arbiter view, master = clients/RAM view.
interface data_mem_arbiter_if
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, disp_req, disp_addr, mem_rdata,
    output core_gnt, core_rvalid, core_rdata, core_stall,
           disp_gnt, disp_rvalid, disp_rdata,
           mem_read, mem_write, mem_addr, mem_wdata, busy
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, disp_req, disp_addr, mem_rdata,
    input  core_gnt, core_rvalid, core_rdata, core_stall,
           disp_gnt, disp_rvalid, disp_rdata,
           mem_read, mem_write, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker; a tie goes to the requester that was not granted last.
module rr_arb2
  import data_mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_e    last_i,
  output req_id_e    winner_o,
  output logic       any_o
);

  always_comb begin
    any_o    = |req_i;
    winner_o = REQ_CORE;
    if (req_i[1] && req_i[0]) begin
      winner_o = (last_i == REQ_CORE) ? REQ_DISP : REQ_CORE;
    end else if (req_i[1]) begin
      winner_o = REQ_DISP;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data RAM between the core (load/store) and the display reader.
// Optional MEMARB_PERF_CNT_EN adds saturating grant and conflict counters.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_arbiter_if.slave   bus
`ifdef MEMARB_PERF_CNT_EN
  ,
  output logic [15:0]         core_gnt_cnt,
  output logic [15:0]         disp_gnt_cnt,
  output logic [15:0]         conflict_cnt
`endif
);

  arb_state_e        state_q;
  req_id_e           win_q;
  req_id_e           last_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              core_gnt_q, disp_gnt_q;
  logic              mem_read_q, mem_write_q;
  logic              core_rvalid_q, disp_rvalid_q;
  logic [DATA_W-1:0] core_rdata_q, disp_rdata_q;

  req_id_e           arb_win;
  logic              arb_any;

  rr_arb2 u_rr_arb2 (
    .req_i    ({bus.disp_req, bus.core_req}),
    .last_i   (last_q),
    .winner_o (arb_win),
    .any_o    (arb_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      win_q         <= REQ_CORE;
      last_q        <= REQ_DISP;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      core_gnt_q    <= 1'b0;
      disp_gnt_q    <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      core_rvalid_q <= 1'b0;
      disp_rvalid_q <= 1'b0;
      core_rdata_q  <= '0;
      disp_rdata_q  <= '0;
    end else begin
      core_gnt_q    <= 1'b0;
      disp_gnt_q    <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      core_rvalid_q <= 1'b0;
      disp_rvalid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // Grant and strobe are registered here so both appear together in ISSUE.
          if (arb_any) begin
            win_q   <= arb_win;
            last_q  <= arb_win;
            state_q <= ST_ISSUE;
            if (arb_win == REQ_CORE) begin
              we_q        <= bus.core_we;
              addr_q      <= bus.core_addr;
              wdata_q     <= bus.core_wdata;
              core_gnt_q  <= 1'b1;
              mem_read_q  <= ~bus.core_we;
              mem_write_q <= bus.core_we;
            end else begin
              we_q       <= 1'b0;
              addr_q     <= bus.disp_addr;
              disp_gnt_q <= 1'b1;
              mem_read_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          state_q <= we_q ? ST_IDLE : ST_RDWAIT;
        end
        ST_RDWAIT: begin
          if (win_q == REQ_CORE) begin
            core_rdata_q  <= bus.mem_rdata;
            core_rvalid_q <= 1'b1;
          end else begin
            disp_rdata_q  <= bus.mem_rdata;
            disp_rvalid_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.core_gnt    = core_gnt_q;
  assign bus.disp_gnt    = disp_gnt_q;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.disp_rvalid = disp_rvalid_q;
  assign bus.core_rdata  = core_rdata_q;
  assign bus.disp_rdata  = disp_rdata_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.core_stall  = bus.core_req & ~core_gnt_q;

`ifdef MEMARB_PERF_CNT_EN
  logic [15:0] core_cnt_q, disp_cnt_q, conf_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_cnt_q <= '0;
      disp_cnt_q <= '0;
      conf_cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (arb_any && arb_win == REQ_CORE) core_cnt_q <= sat_inc16(core_cnt_q);
      if (arb_any && arb_win == REQ_DISP) disp_cnt_q <= sat_inc16(disp_cnt_q);
      if (bus.core_req && bus.disp_req)   conf_cnt_q <= sat_inc16(conf_cnt_q);
    end
  end

  assign core_gnt_cnt = core_cnt_q;
  assign disp_gnt_cnt = disp_cnt_q;
  assign conflict_cnt = conf_cnt_q;
`endif

endmodule
